// File: rtl/td4_pkg.sv
// ---------------------------------------------------------------------------
// td4_pkg: shared definitions for the 4-bit CPU's instruction memory.
//   ADDR_WIDTH / DATA_WIDTH : default fetch address and instruction widths
//   NOP_WORD                : instruction word the CPU treats as no-op
//   rom_state_t             : program loader FSM states
// ---------------------------------------------------------------------------
package td4_pkg;

  localparam int ADDR_WIDTH = 4;
  localparam int DATA_WIDTH = 8;

  localparam logic [DATA_WIDTH-1:0] NOP_WORD = '0;

  typedef enum logic [1:0] {
    ROM_RUN  = 2'd0,  // CPU runs, fetches served from the array
    ROM_LOAD = 2'd1,  // host is writing a new image, CPU held
    ROM_DONE = 2'd2   // single-cycle completion marker
  } rom_state_t;

endpackage : td4_pkg

// File: rtl/program_rom_if.sv
// ---------------------------------------------------------------------------
// program_rom_if: fetch and program-load signals of the instruction memory.
//   address    : CPU fetch address                    (master -> slave)
//   data       : instruction word for address          (slave  -> master)
//   load_start : begin/restart a full program load     (master -> slave)
//   load_valid : load_data carries a word              (master -> slave)
//   load_data  : program word, ascending address order (master -> slave)
//   load_ready : memory accepts a word this cycle      (slave  -> master)
//   load_done  : one-cycle pulse after the last word   (slave  -> master)
//   cpu_hold   : CPU must stay in reset                (slave  -> master)
// ---------------------------------------------------------------------------
interface program_rom_if #(
  parameter int ADDR_WIDTH = td4_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = td4_pkg::DATA_WIDTH
);

  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data;
  logic                  load_start;
  logic                  load_valid;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_ready;
  logic                  load_done;
  logic                  cpu_hold;

  // Host/CPU side.
  modport master (
    output address, load_start, load_valid, load_data,
    input  data, load_ready, load_done, cpu_hold
  );

  // Memory side.
  modport slave (
    input  address, load_start, load_valid, load_data,
    output data, load_ready, load_done, cpu_hold
  );

endinterface : program_rom_if

// File: rtl/program_rom_array.sv
// ---------------------------------------------------------------------------
// rom_array: DEPTH x DATA_WIDTH flop array with asynchronous clear.
//   clock, reset : rising-edge clock, async active-high clear to RESET_WORD
//   we/waddr/wdata : single synchronous write port
//   raddr/rdata    : asynchronous (combinational) read port
// ---------------------------------------------------------------------------
module rom_array #(
  parameter int                    ADDR_WIDTH = td4_pkg::ADDR_WIDTH,
  parameter int                    DATA_WIDTH = td4_pkg::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_WORD = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no latch is inferred when the write is idle.
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // NOTE: the array is deliberately reset: a reset in the middle of a load
  // must discard the partial image, so this is a flop array, not a RAM macro.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RESET_WORD;
      end
    end else begin
      // NOTE: sequential state is updated with non-blocking '<=' only.
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : rom_array

// File: rtl/program_rom.sv
// ---------------------------------------------------------------------------
// program_rom: instruction memory for the 4-bit CPU with a host load port.
//   clock : rising-edge system clock
//   reset : asynchronous, active-high; clears the FSM and the whole array
//   bus   : program_rom_if.slave (fetch port + load handshake + cpu_hold)
//
// In ROM_RUN fetches are served combinationally from the array. A
// load_start pulse enters ROM_LOAD, where the CPU is held and fed NOPs while
// the host streams DEPTH words in ascending order. The last write passes
// through a one-cycle ROM_DONE (load_done) before execution resumes from
// address 0. cpu_hold/load_ready/load_done are registered Moore outputs.
// ---------------------------------------------------------------------------
module program_rom #(
  parameter int                    ADDR_WIDTH = td4_pkg::ADDR_WIDTH,
  parameter int                    DATA_WIDTH = td4_pkg::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_WORD = '0
) (
  input  logic            clock,
  input  logic            reset,
  program_rom_if.slave    bus
);

  import td4_pkg::*;

  rom_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  load_ready_q, load_ready_d;
  logic                  load_done_q, load_done_d;
  logic                  cpu_hold_q, cpu_hold_d;

  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Next-state, pointer and write-enable logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    mem_we  = 1'b0;

    unique case (state_q)
      ROM_RUN: begin
        // load_valid is ignored here; only load_start matters.
        if (bus.load_start) begin
          state_d = ROM_LOAD;
          ptr_d   = '0;
        end
      end

      ROM_LOAD: begin
        // Restart wins over a word offered in the same cycle.
        if (bus.load_start) begin
          ptr_d = '0;
        end else if (bus.load_valid) begin
          mem_we = 1'b1;
          ptr_d  = ptr_q + 1'b1;  // wraps to 0 after the last word
          if (ptr_q == '1) begin
            state_d = ROM_DONE;
          end
        end
      end

      ROM_DONE: begin
        state_d = ROM_RUN;
      end

      default: begin
        state_d = ROM_RUN;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so each one
  // equals a pure function of state_q with no path from the inputs.
  always_comb begin
    load_ready_d = (state_d == ROM_LOAD);
    load_done_d  = (state_d == ROM_DONE);
    cpu_hold_d   = (state_d != ROM_RUN);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ROM_RUN;
      ptr_q        <= '0;
      load_ready_q <= 1'b0;
      load_done_q  <= 1'b0;
      cpu_hold_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      load_ready_q <= load_ready_d;
      load_done_q  <= load_done_d;
      cpu_hold_q   <= cpu_hold_d;
    end
  end

  rom_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .RESET_WORD (RESET_WORD)
  ) u_array (
    .clock (clock),
    .reset (reset),
    .we    (mem_we),
    .waddr (ptr_q),
    .wdata (bus.load_data),
    .raddr (bus.address),
    .rdata (mem_rdata)
  );

  // Outside ROM_RUN the CPU sees NOPs regardless of its fetch address.
  assign bus.data       = (state_q == ROM_RUN) ? mem_rdata : DATA_WIDTH'(NOP_WORD);
  assign bus.load_ready = load_ready_q;
  assign bus.load_done  = load_done_q;
  assign bus.cpu_hold   = cpu_hold_q;

endmodule : program_rom

// File: tb/tb_program_rom.sv
// ---------------------------------------------------------------------------
// tb_program_rom: directed self-checking bench for program_rom.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_program_rom;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;

  program_rom_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

  program_rom dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset();
    reset          = 1'b1;
    bus.address    = '0;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    for (int a = 0; a < 16; a++) begin
      bus.address = 4'(a);
      #1;
      n_cmp++;
      if (bus.data !== 8'h00) begin
        $display("FAIL reset_data[%0d]: got %h want 00", a, bus.data); n_err++;
      end
    end
    n_cmp++;
    if (bus.cpu_hold !== 1'b0) begin
      $display("FAIL reset_cpu_hold: got %b want 0", bus.cpu_hold); n_err++;
    end
    n_cmp++;
    if (bus.load_ready !== 1'b0) begin
      $display("FAIL reset_load_ready: got %b want 0", bus.load_ready); n_err++;
    end
    n_cmp++;
    if (bus.load_done !== 1'b0) begin
      $display("FAIL reset_load_done: got %b want 0", bus.load_done); n_err++;
    end
  endtask

  task automatic test_full_load();
    bus.address = 4'd7;
    @(negedge clock);
    bus.load_start = 1'b1;
    @(negedge clock);
    bus.load_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (bus.load_ready !== 1'b1 || bus.cpu_hold !== 1'b1) begin
        $display("FAIL full_ready_hold[%0d]: got ready=%b hold=%b want 1/1",
                 i, bus.load_ready, bus.cpu_hold); n_err++;
      end
      n_cmp++;
      if (bus.load_done !== 1'b0 || bus.data !== 8'h00) begin
        $display("FAIL full_done_data[%0d]: got done=%b data=%h want 0/00",
                 i, bus.load_done, bus.data); n_err++;
      end
      bus.load_valid = 1'b1;
      bus.load_data  = 8'h10 + 8'(i);
      @(negedge clock);
    end
    bus.load_valid = 1'b0;
    n_cmp++;
    if (bus.load_done !== 1'b1 || bus.cpu_hold !== 1'b1 || bus.load_ready !== 1'b0) begin
      $display("FAIL full_done_cycle: got done=%b hold=%b ready=%b want 1/1/0",
               bus.load_done, bus.cpu_hold, bus.load_ready); n_err++;
    end
    n_cmp++;
    if (bus.data !== 8'h00) begin
      $display("FAIL full_done_data: got %h want 00", bus.data); n_err++;
    end
    @(negedge clock);
    n_cmp++;
    if (bus.load_done !== 1'b0 || bus.cpu_hold !== 1'b0 || bus.load_ready !== 1'b0) begin
      $display("FAIL full_after_done: got done=%b hold=%b ready=%b want 0/0/0",
               bus.load_done, bus.cpu_hold, bus.load_ready); n_err++;
    end
    for (int a = 0; a < 16; a++) begin
      bus.address = 4'(a);
      #1;
      n_cmp++;
      if (bus.data !== 8'h10 + 8'(a)) begin
        $display("FAIL full_image[%0d]: got %h want %h", a, bus.data, 8'h10 + 8'(a)); n_err++;
      end
    end
  endtask

  task automatic test_stalled_load();
    // Clear the array first so the new image is visible.
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    bus.address = 4'd9;
    bus.load_start = 1'b1;
    @(negedge clock);
    bus.load_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 8'h10 + 8'(i);
      @(negedge clock);
      bus.load_valid = 1'b0;
      if (i < 15) begin
        for (int g = 0; g < 3; g++) begin
          n_cmp++;
          if (bus.load_done !== 1'b0 || bus.load_ready !== 1'b1 || bus.data !== 8'h00) begin
            $display("FAIL stall_gap[%0d.%0d]: got done=%b ready=%b data=%h want 0/1/00",
                     i, g, bus.load_done, bus.load_ready, bus.data); n_err++;
          end
          @(negedge clock);
        end
      end
    end
    n_cmp++;
    if (bus.load_done !== 1'b1) begin
      $display("FAIL stall_done: got %b want 1", bus.load_done); n_err++;
    end
    @(negedge clock);
    for (int a = 0; a < 16; a++) begin
      bus.address = 4'(a);
      #1;
      n_cmp++;
      if (bus.data !== 8'h10 + 8'(a)) begin
        $display("FAIL stall_image[%0d]: got %h want %h", a, bus.data, 8'h10 + 8'(a)); n_err++;
      end
    end
  endtask

  task automatic test_restart();
    // mem[15] holds 0x1F, so a non-zero data here means NOPs are not forced.
    bus.address = 4'd15;
    @(negedge clock);
    bus.load_start = 1'b1;
    @(negedge clock);
    bus.load_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 8'hA0 + 8'(i);
      @(negedge clock);
    end
    bus.load_start = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = 8'hFF;
    @(negedge clock);
    bus.load_start = 1'b0;
    n_cmp++;
    if (bus.load_ready !== 1'b1 || bus.data !== 8'h00) begin
      $display("FAIL restart_state: got ready=%b data=%h want 1/00",
               bus.load_ready, bus.data); n_err++;
    end
    for (int i = 0; i < 16; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 8'hB0 + 8'(i);
      @(negedge clock);
    end
    bus.load_valid = 1'b0;
    n_cmp++;
    if (bus.load_done !== 1'b1) begin
      $display("FAIL restart_done: got %b want 1", bus.load_done); n_err++;
    end
    @(negedge clock);
    for (int a = 0; a < 16; a++) begin
      bus.address = 4'(a);
      #1;
      n_cmp++;
      if (bus.data !== 8'hB0 + 8'(a)) begin
        $display("FAIL restart_image[%0d]: got %h want %h", a, bus.data, 8'hB0 + 8'(a)); n_err++;
      end
    end
  endtask

  task automatic test_reset_mid_load();
    bus.address = 4'd3;
    @(negedge clock);
    bus.load_start = 1'b1;
    @(negedge clock);
    bus.load_start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 8'hC0 + 8'(i);
      @(negedge clock);
    end
    bus.load_valid = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.cpu_hold !== 1'b0 || bus.load_ready !== 1'b0 || bus.load_done !== 1'b0) begin
      $display("FAIL midreset_outputs: got hold=%b ready=%b done=%b want 0/0/0",
               bus.cpu_hold, bus.load_ready, bus.load_done); n_err++;
    end
    n_cmp++;
    if (bus.data !== 8'h00) begin
      $display("FAIL midreset_data: got %h want 00", bus.data); n_err++;
    end
    #1;
    reset = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (bus.load_ready !== 1'b0 || bus.cpu_hold !== 1'b0) begin
      $display("FAIL midreset_run: got ready=%b hold=%b want 0/0",
               bus.load_ready, bus.cpu_hold); n_err++;
    end
    for (int a = 0; a < 16; a++) begin
      bus.address = 4'(a);
      #1;
      n_cmp++;
      if (bus.data !== 8'h00) begin
        $display("FAIL midreset_image[%0d]: got %h want 00", a, bus.data); n_err++;
      end
    end
  endtask

  task automatic test_ignored_inputs();
    @(negedge clock);
    bus.load_start = 1'b1;
    @(negedge clock);
    bus.load_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 8'h20 + 8'(i);
      @(negedge clock);
    end
    bus.load_valid = 1'b0;
    n_cmp++;
    if (bus.load_done !== 1'b1) begin
      $display("FAIL ignored_done: got %b want 1", bus.load_done); n_err++;
    end
    // load_start during ROM_DONE must not begin a new load.
    bus.load_start = 1'b1;
    @(negedge clock);
    bus.load_start = 1'b0;
    for (int c = 0; c < 2; c++) begin
      n_cmp++;
      if (bus.load_ready !== 1'b0 || bus.cpu_hold !== 1'b0) begin
        $display("FAIL ignored_start[%0d]: got ready=%b hold=%b want 0/0",
                 c, bus.load_ready, bus.cpu_hold); n_err++;
      end
      @(negedge clock);
    end
    // load_valid in ROM_RUN must not write.
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h55;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      n_cmp++;
      if (bus.load_ready !== 1'b0) begin
        $display("FAIL ignored_valid[%0d]: got ready=%b want 0", c, bus.load_ready); n_err++;
      end
    end
    bus.load_valid = 1'b0;
    for (int a = 0; a < 16; a++) begin
      bus.address = 4'(a);
      #1;
      n_cmp++;
      if (bus.data !== 8'h20 + 8'(a)) begin
        $display("FAIL ignored_image[%0d]: got %h want %h", a, bus.data, 8'h20 + 8'(a)); n_err++;
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_full_load();
    test_stalled_load();
    test_restart();
    test_reset_mid_load();
    test_ignored_inputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_program_rom
